// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32 five-stage pipeline control unit:
// FSM state encodings, stage indices and the PC reset value.
package pipe_pkg;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_STALL   = 2'd1,
    S_MEMWAIT = 2'd2
  } state_e;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_DE  = 1;
  localparam int unsigned STG_EXE = 2;
  localparam int unsigned STG_ACC = 3;
  localparam int unsigned STG_WB  = 4;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// W-bit up counter that sticks at all-ones, with synchronous clear and
// synchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // next count: clear wins, increment only below the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: turns hazard stalls, EXE redirects and data-memory waits
// into per-stage enables, bubbles and valid tracking for IF/DE/EXE/ACC/WB.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned STALL_MAX = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             redirect_exe,
  input  logic [31:0]      redirect_pc,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic             de_en,
  output logic             exe_en,
  output logic             acc_en,
  output logic             wb_en,
  output logic             de_valid,
  output logic             exe_valid,
  output logic             acc_valid,
  output logic             wb_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_err
);

  localparam int unsigned       RUN_W     = $clog2(STALL_MAX + 2);
  localparam logic [RUN_W-1:0]  STALL_LIM = RUN_W'(STALL_MAX);

  state_e      state_d, state_q;
  logic        de_valid_d, de_valid_q;
  logic        exe_valid_d, exe_valid_q;
  logic        acc_valid_d, acc_valid_q;
  logic        wb_valid_d, wb_valid_q;
  logic [31:0] pc_target_d, pc_target_q;
  logic        stall_err_d, stall_err_q;

  logic        mem_hold_s;
  logic        redir_take_s;
  logic        stall_take_s;
  logic        run_clr_s;
  logic [RUN_W-1:0] run_cnt_s;

  // Requests only count when the stage they concern holds a real instruction.
  assign mem_hold_s   = dmem_busy    & acc_valid_q;
  assign redir_take_s = redirect_exe & exe_valid_q;
  assign stall_take_s = hazard_stall & de_valid_q;

  // priority decode of enables, valid propagation and next state
  always_comb begin
    pc_en        = 1'b0;
    pc_sel       = 1'b0;
    de_en        = 1'b0;
    exe_en       = 1'b0;
    acc_en       = 1'b0;
    wb_en        = 1'b0;
    run_clr_s    = 1'b0;
    state_d      = state_q;
    de_valid_d   = de_valid_q;
    exe_valid_d  = exe_valid_q;
    acc_valid_d  = acc_valid_q;
    wb_valid_d   = wb_valid_q;
    pc_target_d  = pc_target_q;
    stall_err_d  = stall_err_q;
    if (rst) begin
      state_d = S_RUN;
    end else if (mem_hold_s) begin
      // freeze everything; held inputs are re-evaluated when memory is ready
      state_d = S_MEMWAIT;
    end else if (redir_take_s) begin
      pc_en       = 1'b1;
      pc_sel      = 1'b1;
      de_en       = 1'b1;
      exe_en      = 1'b1;
      acc_en      = 1'b1;
      wb_en       = 1'b1;
      run_clr_s   = 1'b1;
      pc_target_d = redirect_pc;
      de_valid_d  = 1'b0;
      exe_valid_d = 1'b0;
      acc_valid_d = 1'b1;
      wb_valid_d  = acc_valid_q;
      state_d     = S_RUN;
    end else if (stall_take_s) begin
      exe_en      = 1'b1;
      acc_en      = 1'b1;
      wb_en       = 1'b1;
      exe_valid_d = 1'b0;
      acc_valid_d = exe_valid_q;
      wb_valid_d  = acc_valid_q;
      state_d     = S_STALL;
      if (run_cnt_s >= STALL_LIM) begin
        stall_err_d = 1'b1;
      end else begin
        stall_err_d = stall_err_q;
      end
    end else begin
      pc_en       = 1'b1;
      de_en       = 1'b1;
      exe_en      = 1'b1;
      acc_en      = 1'b1;
      wb_en       = 1'b1;
      run_clr_s   = 1'b1;
      de_valid_d  = 1'b1;
      exe_valid_d = de_valid_q;
      acc_valid_d = exe_valid_q;
      wb_valid_d  = acc_valid_q;
      state_d     = S_RUN;
    end
  end

  // control state, valid bits, redirect target and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      de_valid_q  <= 1'b0;
      exe_valid_q <= 1'b0;
      acc_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      pc_target_q <= PC_RESET;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      de_valid_q  <= de_valid_d;
      exe_valid_q <= exe_valid_d;
      acc_valid_q <= acc_valid_d;
      wb_valid_q  <= wb_valid_d;
      pc_target_q <= pc_target_d;
      stall_err_q <= stall_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (stall_take_s & ~mem_hold_s & ~redir_take_s),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (redir_take_s & ~mem_hold_s),
    .cnt (flush_cnt)
  );

  // consecutive stall cycles; a memory freeze neither extends nor breaks a run
  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .clr (run_clr_s),
    .inc (stall_take_s & ~mem_hold_s & ~redir_take_s),
    .cnt (run_cnt_s)
  );

  assign pc_target = pc_target_q;
  assign de_valid  = de_valid_q;
  assign exe_valid = exe_valid_q;
  assign acc_valid = acc_valid_q;
  assign wb_valid  = wb_valid_q;
  assign stall_err = stall_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: fill, stall, redirect, redirect-vs-stall,
// memory freeze with pending redirect, and the sticky stall error.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_stall;
  logic        redirect_exe;
  logic [31:0] redirect_pc;
  logic        dmem_busy;
  logic        pc_en, pc_sel;
  logic [31:0] pc_target;
  logic        de_en, exe_en, acc_en, wb_en;
  logic        de_valid, exe_valid, acc_valid, wb_valid;
  logic [15:0] stall_cnt, flush_cnt;
  logic        stall_err;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.STALL_MAX(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard_stall (hazard_stall),
    .redirect_exe (redirect_exe),
    .redirect_pc  (redirect_pc),
    .dmem_busy    (dmem_busy),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .pc_target    (pc_target),
    .de_en        (de_en),
    .exe_en       (exe_en),
    .acc_en       (acc_en),
    .wb_en        (wb_en),
    .de_valid     (de_valid),
    .exe_valid    (exe_valid),
    .acc_valid    (acc_valid),
    .wb_valid     (wb_valid),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .stall_err    (stall_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_valids(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, de_valid, exe_valid, acc_valid, wb_valid}, {28'd0, exp});
  endtask

  initial begin
    rst = 1'b1; hazard_stall = 1'b0; redirect_exe = 1'b0;
    redirect_pc = 32'h0; dmem_busy = 1'b0;
    step(); step();

    // reset state and combinational outputs while rst is high
    check_valids("rst_valids", 4'b0000);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    check("rst_stall_err", {31'd0, stall_err}, 32'd0);
    check("rst_pc_target", pc_target, 32'h0);
    check("rst_pc_en", {31'd0, pc_en}, 32'd0);
    check("rst_enables", {28'd0, de_en, exe_en, acc_en, wb_en}, 32'd0);

    // first fetch cycle; requests with invalid stages are ignored
    rst = 1'b0; hazard_stall = 1'b1; redirect_exe = 1'b1; redirect_pc = 32'hdead_0000;
    #1;
    check("first_pc_en", {31'd0, pc_en}, 32'd1);
    check("ign_pc_sel", {31'd0, pc_sel}, 32'd0);
    step();
    hazard_stall = 1'b0; redirect_exe = 1'b0;
    check("ign_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("ign_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    check_valids("fill_1", 4'b1000);
    for (int i = 2; i <= 4; i++) begin
      step();
      check_valids($sformatf("fill_%0d", i), (i == 2) ? 4'b1100 : (i == 3) ? 4'b1110 : 4'b1111);
    end
    step(); step();
    check_valids("full", 4'b1111);

    // single-cycle load-use stall
    hazard_stall = 1'b1;
    #1;
    check("stall_pc_en", {31'd0, pc_en}, 32'd0);
    check("stall_de_en", {31'd0, de_en}, 32'd0);
    check("stall_exe_en", {31'd0, exe_en}, 32'd1);
    step();
    hazard_stall = 1'b0;
    check_valids("bubble_exe", 4'b1011);
    check("stall_cnt_1", {16'd0, stall_cnt}, 32'd1);
    step();
    check_valids("bubble_acc", 4'b1101);
    step();
    check_valids("bubble_wb", 4'b1110);

    // redirect from EXE
    redirect_exe = 1'b1; redirect_pc = 32'h0000_0100;
    #1;
    check("redir_pc_sel", {31'd0, pc_sel}, 32'd1);
    check("redir_pc_en", {31'd0, pc_en}, 32'd1);
    step();
    redirect_exe = 1'b0;
    #1;
    check("redir_target", pc_target, 32'h0000_0100);
    check_valids("redir_squash", 4'b0011);
    check("flush_cnt_1", {16'd0, flush_cnt}, 32'd1);
    check("redir_pc_sel_off", {31'd0, pc_sel}, 32'd0);
    step(); step();
    check_valids("refill_a", 4'b1100);

    // redirect and stall together: redirect wins
    redirect_exe = 1'b1; hazard_stall = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    check("both_pc_en", {31'd0, pc_en}, 32'd1);
    step();
    redirect_exe = 1'b0; hazard_stall = 1'b0;
    check("both_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    check("both_flush_cnt", {16'd0, flush_cnt}, 32'd2);
    check("both_target", pc_target, 32'h0000_0200);
    check_valids("both_valids", 4'b0010);
    step(); step(); step();
    check_valids("refill_b", 4'b1110);

    // memory freeze with a pending redirect
    dmem_busy = 1'b1; redirect_exe = 1'b1; redirect_pc = 32'h0000_0300;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("mw_en_%0d", i), {26'd0, pc_en, pc_sel, de_en, exe_en, acc_en, wb_en}, 32'd0);
      step();
      check_valids($sformatf("mw_valids_%0d", i), 4'b1110);
      check($sformatf("mw_flush_%0d", i), {16'd0, flush_cnt}, 32'd2);
      check($sformatf("mw_target_%0d", i), pc_target, 32'h0000_0200);
    end
    dmem_busy = 1'b0;
    #1;
    check("mw_release_sel", {31'd0, pc_sel}, 32'd1);
    step();
    redirect_exe = 1'b0;
    check("mw_flush_cnt", {16'd0, flush_cnt}, 32'd3);
    check("mw_target", pc_target, 32'h0000_0300);
    check_valids("mw_squash", 4'b0011);

    // mid-run reset, then a 6-cycle stall that trips the error
    rst = 1'b1;
    step();
    check_valids("rst2_valids", 4'b0000);
    check("rst2_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    check("rst2_target", pc_target, 32'h0);
    rst = 1'b0;
    step();
    hazard_stall = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      #1;
      check($sformatf("long_pc_en_%0d", i), {31'd0, pc_en}, 32'd0);
      step();
      check($sformatf("long_err_%0d", i), {31'd0, stall_err}, (i >= 5) ? 32'd1 : 32'd0);
    end
    hazard_stall = 1'b0;
    check("long_stall_cnt", {16'd0, stall_cnt}, 32'd6);
    step(); step();
    check("err_sticky", {31'd0, stall_err}, 32'd1);
    rst = 1'b1;
    step();
    check("err_cleared", {31'd0, stall_err}, 32'd0);
    check("rst3_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
